execute_stage: RTL and testbench



---
 rtl/execute_stage.sv | 159 +++++++++++++++
 tb/tb_execute_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
// Runs the ALU on A/B, resolves beq/bne/j and loads the EX/MEM register.
// The PC redirect (taken flag + target) back to fetch is registered as well.
// Per-edge priority: rst > flush > stall > normal load.
module execute_stage #(
    parameter int DATA_W   = 32,
    parameter int RD_W     = 5,
    parameter int ALUCTR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                MemtoReg,
    input  logic                RegWrite,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic                branch,
    input  logic                jump,
    input  logic [ALUCTR_W-1:0] ALUctr,
    input  logic [DATA_W-1:0]   JT,
    input  logic [DATA_W-1:0]   NPC,
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    input  logic [15:0]         imm,
    input  logic [RD_W-1:0]     RD,
    input  logic [DATA_W-1:0]   MD,
    output logic                XM_MemtoReg,
    output logic                XM_RegWrite,
    output logic                XM_MemRead,
    output logic                XM_MemWrite,
    output logic [DATA_W-1:0]   XM_ALUout,
    output logic [DATA_W-1:0]   XM_MD,
    output logic [RD_W-1:0]     XM_RD,
    output logic                XM_Redirect,
    output logic [DATA_W-1:0]   XM_Target
);

    localparam logic [ALUCTR_W-1:0] ALU_ADD = ALUCTR_W'(0);
    localparam logic [ALUCTR_W-1:0] ALU_SUB = ALUCTR_W'(1);
    localparam logic [ALUCTR_W-1:0] ALU_AND = ALUCTR_W'(2);
    localparam logic [ALUCTR_W-1:0] ALU_OR  = ALUCTR_W'(3);
    localparam logic [ALUCTR_W-1:0] ALU_SLT = ALUCTR_W'(4);
    localparam logic [ALUCTR_W-1:0] ALU_BNE = ALUCTR_W'(5);

    // Combinational EX results feeding the EX/MEM register
    logic [DATA_W-1:0] diff_s;
    logic              zero_s;
    logic              taken_s;
    logic [DATA_W-1:0] branch_target_s;
    logic [DATA_W-1:0] alu_d;
    logic              redirect_d;
    logic [DATA_W-1:0] target_d;

    // EX/MEM register state
    logic              memtoreg_q;
    logic              regwrite_q;
    logic              memread_q;
    logic              memwrite_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] md_q;
    logic [RD_W-1:0]   rd_q;
    logic              redirect_q;
    logic [DATA_W-1:0] target_q;

    // ALU, zero flag, branch resolution and redirect target selection
    always_comb begin
        alu_d           = {DATA_W{1'b0}};
        diff_s          = A - B;
        // zero depends only on A-B so beq/bne resolve regardless of ALU op
        zero_s          = (diff_s == {DATA_W{1'b0}});
        branch_target_s = NPC + {{(DATA_W-18){imm[15]}}, imm, 2'b00};

        case (ALUctr)
            ALU_ADD: alu_d = A + B;
            ALU_SUB: alu_d = diff_s;
            ALU_AND: alu_d = A & B;
            ALU_OR:  alu_d = A | B;
            ALU_SLT: alu_d = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_BNE: alu_d = diff_s;
            default: alu_d = {DATA_W{1'b0}};
        endcase

        // Only a beq (sub) or bne op can take a branch
        if (branch == 1'b1) begin
            taken_s = ((ALUctr == ALU_SUB) && zero_s) ||
                      ((ALUctr == ALU_BNE) && !zero_s);
        end else begin
            taken_s = 1'b0;
        end

        redirect_d = taken_s | jump;

        // Jump overrides a simultaneous branch; no redirect reports target 0
        if (jump == 1'b1) begin
            target_d = JT;
        end else if (taken_s == 1'b1) begin
            target_d = branch_target_s;
        end else begin
            target_d = {DATA_W{1'b0}};
        end
    end

    // EX/MEM pipeline register with reset, flush-to-bubble and stall hold
    always_ff @(posedge clk) begin
        if (rst) begin
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            alu_q      <= {DATA_W{1'b0}};
            md_q       <= {DATA_W{1'b0}};
            rd_q       <= {RD_W{1'b0}};
            redirect_q <= 1'b0;
            target_q   <= {DATA_W{1'b0}};
        end else if (flush) begin
            // Bubble: kill every side effect; data registers simply hold
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            rd_q       <= {RD_W{1'b0}};
            redirect_q <= 1'b0;
            target_q   <= {DATA_W{1'b0}};
        end else if (stall) begin
            // Hold everything, including the redirect fetch is consuming
            memtoreg_q <= memtoreg_q;
            regwrite_q <= regwrite_q;
            memread_q  <= memread_q;
            memwrite_q <= memwrite_q;
            alu_q      <= alu_q;
            md_q       <= md_q;
            rd_q       <= rd_q;
            redirect_q <= redirect_q;
            target_q   <= target_q;
        end else begin
            memtoreg_q <= MemtoReg;
            regwrite_q <= RegWrite;
            memread_q  <= MemRead;
            memwrite_q <= MemWrite;
            alu_q      <= alu_d;
            md_q       <= MD;
            rd_q       <= RD;
            redirect_q <= redirect_d;
            target_q   <= target_d;
        end
    end

    assign XM_MemtoReg = memtoreg_q;
    assign XM_RegWrite = regwrite_q;
    assign XM_MemRead  = memread_q;
    assign XM_MemWrite = memwrite_q;
    assign XM_ALUout   = alu_q;
    assign XM_MD       = md_q;
    assign XM_RD       = rd_q;
    assign XM_Redirect = redirect_q;
    assign XM_Target   = target_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed, table-driven bench for execute_stage.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        MemtoReg, RegWrite, MemRead, MemWrite, branch, jump;
    logic [2:0]  ALUctr;
    logic [31:0] JT, NPC, A, B, MD;
    logic [15:0] imm;
    logic [4:0]  RD;
    logic        XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite;
    logic [31:0] XM_ALUout, XM_MD, XM_Target;
    logic [4:0]  XM_RD;
    logic        XM_Redirect;

    int total = 0;
    int bad   = 0;

    execute_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .branch(branch), .jump(jump), .ALUctr(ALUctr), .JT(JT), .NPC(NPC),
        .A(A), .B(B), .imm(imm), .RD(RD), .MD(MD),
        .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite), .XM_MemRead(XM_MemRead),
        .XM_MemWrite(XM_MemWrite), .XM_ALUout(XM_ALUout), .XM_MD(XM_MD), .XM_RD(XM_RD),
        .XM_Redirect(XM_Redirect), .XM_Target(XM_Target)
    );

    always #5 clk = ~clk;

    // ctrl = {MemtoReg, RegWrite, MemRead, MemWrite}
    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic        br;
        logic        jp;
        logic [2:0]  op;
        logic [31:0] jt;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] imm;
        logic [4:0]  rd;
        logic [31:0] md;
        logic [31:0] e_alu;
        logic        e_red;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(string name, logic [3:0] ctrl, logic br, logic jp, logic [2:0] op,
                                logic [31:0] jt, logic [31:0] npc, logic [31:0] a, logic [31:0] b,
                                logic [15:0] im, logic [4:0] rd, logic [31:0] md,
                                logic [31:0] e_alu, logic e_red, logic [31:0] e_tgt);
        vec_t v;
        v.name = name; v.ctrl = ctrl; v.br = br; v.jp = jp; v.op = op;
        v.jt = jt; v.npc = npc; v.a = a; v.b = b; v.imm = im; v.rd = rd; v.md = md;
        v.e_alu = e_alu; v.e_red = e_red; v.e_tgt = e_tgt;
        return v;
    endfunction

    function automatic logic [105:0] outs();
        return {XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite,
                XM_ALUout, XM_MD, XM_RD, XM_Redirect, XM_Target};
    endfunction

    function automatic logic [105:0] expect_of(vec_t v);
        return {v.ctrl, v.e_alu, v.md, v.rd, v.e_red, v.e_tgt};
    endfunction

    task automatic check(string name, logic [105:0] act, logic [105:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        {MemtoReg, RegWrite, MemRead, MemWrite} = v.ctrl;
        branch = v.br; jump = v.jp; ALUctr = v.op; JT = v.jt; NPC = v.npc;
        A = v.a; B = v.b; imm = v.imm; RD = v.rd; MD = v.md;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t lw, sw, jv;

        //            name        ctrl    br    jp    op    jt            npc           a             b             imm       rd     md            alu           red   tgt
        vecs[0]  = mk("add",      4'b0100, 1'b0, 1'b0, 3'd0, 32'h0,        32'h0,        32'd7,        32'd5,        16'h0,    5'd3,  32'h11,       32'd12,       1'b0, 32'h0);
        vecs[1]  = mk("sub",      4'b0100, 1'b0, 1'b0, 3'd1, 32'h0,        32'h0,        32'd7,        32'd5,        16'h0,    5'd4,  32'h22,       32'd2,        1'b0, 32'h0);
        vecs[2]  = mk("and",      4'b0100, 1'b0, 1'b0, 3'd2, 32'h0,        32'h0,        32'd7,        32'd5,        16'h0,    5'd5,  32'h33,       32'd5,        1'b0, 32'h0);
        vecs[3]  = mk("or",       4'b0100, 1'b0, 1'b0, 3'd3, 32'h0,        32'h0,        32'd7,        32'd5,        16'h0,    5'd6,  32'h44,       32'd7,        1'b0, 32'h0);
        vecs[4]  = mk("slt_neg",  4'b0100, 1'b0, 1'b0, 3'd4, 32'h0,        32'h0,        32'hFFFFFFFF, 32'd1,        16'h0,    5'd7,  32'h0,        32'd1,        1'b0, 32'h0);
        vecs[5]  = mk("slt_pos",  4'b0100, 1'b0, 1'b0, 3'd4, 32'h0,        32'h0,        32'd1,        32'hFFFFFFFF, 16'h0,    5'd8,  32'h0,        32'd0,        1'b0, 32'h0);
        vecs[6]  = mk("add_wrap", 4'b0100, 1'b0, 1'b0, 3'd0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'd1,        16'h0,    5'd9,  32'h0,        32'd0,        1'b0, 32'h0);
        vecs[7]  = mk("op6",      4'b0100, 1'b0, 1'b0, 3'd6, 32'h0,        32'h0,        32'd7,        32'd5,        16'h0,    5'd10, 32'h0,        32'd0,        1'b0, 32'h0);
        vecs[8]  = mk("op7",      4'b0100, 1'b0, 1'b0, 3'd7, 32'h0,        32'h0,        32'd7,        32'd5,        16'h0,    5'd11, 32'h0,        32'd0,        1'b0, 32'h0);
        vecs[9]  = mk("beq_tk",   4'b0000, 1'b1, 1'b0, 3'd1, 32'h0,        32'h100,      32'd9,        32'd9,        16'hFFFE, 5'd0,  32'd9,        32'd0,        1'b1, 32'hF8);
        vecs[10] = mk("beq_nt",   4'b0000, 1'b1, 1'b0, 3'd1, 32'h0,        32'h100,      32'd9,        32'd8,        16'hFFFE, 5'd0,  32'd8,        32'd1,        1'b0, 32'h0);
        vecs[11] = mk("bne_tk",   4'b0000, 1'b1, 1'b0, 3'd5, 32'h0,        32'h40,       32'd1,        32'd2,        16'h3,    5'd0,  32'd2,        32'hFFFFFFFF, 1'b1, 32'h4C);
        vecs[12] = mk("bne_nt",   4'b0000, 1'b1, 1'b0, 3'd5, 32'h0,        32'h40,       32'd5,        32'd5,        16'h3,    5'd0,  32'd5,        32'd0,        1'b0, 32'h0);
        vecs[13] = mk("j_br",     4'b0000, 1'b1, 1'b1, 3'd1, 32'h00400020, 32'h100,      32'd9,        32'd9,        16'hFFFE, 5'd0,  32'd0,        32'd0,        1'b1, 32'h00400020);
        vecs[14] = mk("br_add",   4'b0000, 1'b1, 1'b0, 3'd0, 32'h0,        32'h100,      32'd9,        32'd9,        16'h4,    5'd0,  32'd0,        32'd18,       1'b0, 32'h0);
        vecs[15] = mk("j_only",   4'b0000, 1'b0, 1'b1, 3'd0, 32'h0FFFFFFC, 32'h200,      32'd0,        32'd0,        16'h0,    5'd0,  32'd0,        32'd0,        1'b1, 32'h0FFFFFFC);
        vecs[16] = mk("lw",       4'b1110, 1'b0, 1'b0, 3'd0, 32'h0,        32'h0,        32'h10,       32'h4,        16'h4,    5'd12, 32'h0,        32'h14,       1'b0, 32'h0);
        vecs[17] = mk("sw",       4'b0001, 1'b0, 1'b0, 3'd0, 32'h0,        32'h0,        32'h20,       32'h8,        16'h8,    5'd13, 32'hCAFEF00D, 32'h28,       1'b0, 32'h0);
        lw = vecs[16];
        sw = vecs[17];
        jv = vecs[13];

        // Reset with nonzero inputs, held for two edges
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(lw);
        tick();
        check("reset_1", outs(), 106'd0);
        drive(jv);
        tick();
        check("reset_2", outs(), 106'd0);
        rst = 1'b0;

        // Table of single-cycle vectors
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i]);
            tick();
            check(vecs[i].name, outs(), expect_of(vecs[i]));
        end

        // Stall: lw captured, then three stalled edges with changing inputs
        drive(lw);
        tick();
        check("stall_load", outs(), expect_of(lw));
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(vecs[i * 4 + 1]);
            tick();
            check("stall_hold", outs(), expect_of(lw));
        end
        stall = 1'b0;

        // Redirect held through stall, then flush+stall kills it
        drive(jv);
        tick();
        check("jump_load", outs(), expect_of(jv));
        stall = 1'b1;
        drive(sw);
        tick();
        check("stall_redirect", outs(), expect_of(jv));
        flush = 1'b1;
        tick();
        check("flush_stall", {96'd0, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_RD, XM_Redirect},
              106'd0);
        check("flush_target", {74'd0, XM_Target}, 106'd0);

        // Load lw, then reset together with flush and stall
        flush = 1'b0; stall = 1'b0;
        drive(lw);
        tick();
        check("pre_rst", outs(), expect_of(lw));
        rst = 1'b1; flush = 1'b1; stall = 1'b1;
        drive(sw);
        tick();
        check("rst_flush", outs(), 106'd0);
        rst = 1'b0; flush = 1'b0; stall = 1'b0;

        // Normal operation resumes after reset
        drive(sw);
        tick();
        check("post_rst", outs(), expect_of(sw));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
